// File: rtl/ifu_seq.sv
// Instruction fetch sequencer: walks a 1024-word window from RESET_PC to
// LAST_PC, registers each fetched word with its address, and honours
// stall, halt and redirect requests. Illegal addresses halt with a sticky err.
module ifu_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] LAST_PC  = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_rd,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        STALL,
        HALT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;
    logic        err_nxt;
    logic        redirect_ok;

    // pc only ever holds a legal address, so im_addr is always in range
    assign im_addr = pc[11:2];
    assign halted  = (state == HALT);

    assign redirect_ok = (redirect_pc >= RESET_PC) &&
                         (redirect_pc <= LAST_PC)  &&
                         (redirect_pc[1:0] == 2'b00);

    // Next-state and register updates; priority redirect > halt > stall
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        valid_nxt  = valid_out;
        err_nxt    = err;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH, STALL: begin
                if (redirect_en) begin
                    valid_nxt = 1'b0;
                    if (redirect_ok) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HALT;
                        err_nxt   = 1'b1;
                    end
                end else if (halt_req) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    state_nxt = STALL;
                end else if (state == STALL) begin
                    // resume cycle: no register update, fetch restarts next cycle
                    state_nxt = FETCH;
                end else begin
                    instr_nxt  = im_rd;
                    pc_out_nxt = pc;
                    valid_nxt  = 1'b1;
                    if (pc == LAST_PC) begin
                        // last word is delivered on this edge; pc stays at LAST_PC
                        state_nxt = HALT;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt = pc + 32'd4;
                    end
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            instr_out <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr_out <= instr_nxt;
            pc_out    <= pc_out_nxt;
            valid_out <= valid_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ifu_seq.sv
// Directed bench for ifu_seq: expected fetches are queued when a fetch cycle
// is driven and compared against pc_out/instr_out after the clock edge.
module tb_ifu_seq;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt_req;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [9:0]  im_addr;
    logic [31:0] im_rd;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        halted;
    logic        err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          errors;
    logic [31:0] mpc;
    logic [31:0] bad_targets[3];

    ifu_seq #(
        .RESET_PC(32'h0000_3000),
        .LAST_PC (32'h0000_3FFC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .halt_req   (halt_req),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .im_addr    (im_addr),
        .im_rd      (im_rd),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .valid_out  (valid_out),
        .halted     (halted),
        .err        (err)
    );

    // Memory model: each word holds its own word index
    assign im_rd = {22'b0, im_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr >> 2) & 32'h0000_03FF;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_pc"}, pc_out, e.pc);
            check({tag, "_instr"}, instr_out, e.instr);
        end
    endtask

    // One sequential fetch cycle at the model pc
    task automatic fetch_step(input string tag);
        exp_t e;
        e.pc    = mpc;
        e.instr = mem_word(mpc);
        q.push_back(e);
        tick();
        pop_check(tag);
        check({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        mpc = mpc + 32'd4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        stall       = 1'b0;
        halt_req    = 1'b0;
        redirect_en = 1'b0;
        mpc         = 32'h0000_3000;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        halt_req    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        mpc         = 32'h0000_3000;
        bad_targets[0] = 32'h0000_3102;
        bad_targets[1] = 32'h0000_2FFC;
        bad_targets[2] = 32'h0000_4000;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_im_addr", {22'b0, im_addr}, 32'h000);

        // BOOT cycle ignores control inputs
        reset    = 1'b0;
        stall    = 1'b1;
        halt_req = 1'b1;
        tick();
        stall    = 1'b0;
        halt_req = 1'b0;
        check("boot_valid", {31'b0, valid_out}, 32'd0);
        check("boot_halted", {31'b0, halted}, 32'd0);

        // Sequential fetch 0x3000, 0x3004, 0x3008
        fetch_step("seq0");
        fetch_step("seq1");
        fetch_step("seq2");

        // Stall three cycles, then one resume cycle with outputs frozen
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc_out", pc_out, 32'h0000_3008);
            check("stall_valid", {31'b0, valid_out}, 32'd1);
        end
        check("stall_im_addr", {22'b0, im_addr}, 32'h003);
        stall = 1'b0;
        tick();
        check("resume_pc_out", pc_out, 32'h0000_3008);
        check("resume_instr", instr_out, 32'h0000_0002);
        fetch_step("after_stall");

        // Legal redirect from FETCH: bubble, then target word
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_3100;
        tick();
        redirect_en = 1'b0;
        check("redir_valid", {31'b0, valid_out}, 32'd0);
        check("redir_pc_out_held", pc_out, 32'h0000_300C);
        check("redir_im_addr", {22'b0, im_addr}, 32'h040);
        mpc = 32'h0000_3100;
        fetch_step("redir_tgt");
        fetch_step("redir_tgt1");

        // Legal redirect while in STALL overrides stall
        stall = 1'b1;
        tick();
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_3200;
        tick();
        redirect_en = 1'b0;
        stall       = 1'b0;
        check("stall_redir_valid", {31'b0, valid_out}, 32'd0);
        check("stall_redir_halted", {31'b0, halted}, 32'd0);
        mpc = 32'h0000_3200;
        fetch_step("stall_redir_tgt");

        // Run into LAST_PC: 0x3FF8, 0x3FFC delivered, then halt with err
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_3FF8;
        tick();
        redirect_en = 1'b0;
        mpc = 32'h0000_3FF8;
        fetch_step("end_3ff8");
        begin
            exp_t e;
            e.pc    = 32'h0000_3FFC;
            e.instr = mem_word(32'h0000_3FFC);
            q.push_back(e);
        end
        tick();
        pop_check("end_3ffc");
        check("end_halted", {31'b0, halted}, 32'd1);
        check("end_err", {31'b0, err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("end_valid", {31'b0, valid_out}, 32'd0);
            check("end_pc_out_held", pc_out, 32'h0000_3FFC);
            check("end_im_addr", {22'b0, im_addr}, 32'h3FF);
        end

        // Reset out of HALT
        do_reset();
        check("rst2_halted", {31'b0, halted}, 32'd0);
        check("rst2_err", {31'b0, err}, 32'd0);
        check("rst2_pc_out", pc_out, 32'd0);
        check("rst2_instr", instr_out, 32'd0);
        tick();
        fetch_step("rst2_first");

        // halt_req with stall in the same cycle: HALT without err
        halt_req = 1'b1;
        stall    = 1'b1;
        tick();
        halt_req = 1'b0;
        stall    = 1'b0;
        check("hreq_halted", {31'b0, halted}, 32'd1);
        check("hreq_err", {31'b0, err}, 32'd0);
        check("hreq_valid", {31'b0, valid_out}, 32'd0);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_3400;
        tick();
        check("hreq_absorb", {31'b0, halted}, 32'd1);
        check("hreq_im_addr", {22'b0, im_addr}, 32'h001);

        // Reset in HALT wins over a pending redirect
        do_reset();
        check("rst3_halted", {31'b0, halted}, 32'd0);
        check("rst3_valid", {31'b0, valid_out}, 32'd0);
        check("rst3_pc_out", pc_out, 32'd0);
        check("rst3_im_addr", {22'b0, im_addr}, 32'h000);
        tick();
        fetch_step("rst3_first");

        // Illegal redirect targets halt with sticky err
        for (int i = 0; i < 3; i++) begin
            redirect_en = 1'b1;
            redirect_pc = bad_targets[i];
            tick();
            redirect_en = 1'b0;
            check("bad_halted", {31'b0, halted}, 32'd1);
            check("bad_err", {31'b0, err}, 32'd1);
            check("bad_valid", {31'b0, valid_out}, 32'd0);
            check("bad_im_addr", {22'b0, im_addr}, 32'h001);
            redirect_en = 1'b1;
            redirect_pc = 32'h0000_3100;
            tick();
            redirect_en = 1'b0;
            check("bad_absorb", {31'b0, halted}, 32'd1);
            check("bad_im_addr_held", {22'b0, im_addr}, 32'h001);
            do_reset();
            check("bad_rst_err", {31'b0, err}, 32'd0);
            tick();
            fetch_step("bad_refetch");
        end

        checks++;
        assert (q.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_seq.md
IFU_SEQ -- requirements
Module: ifu_seq

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, byte address of the first fetch after reset.
REQ-002 Parameter: LAST_PC, 32'h0000_3FFC, highest legal fetch address; 1024 words from RESET_PC.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: stall  in  1  downstream cannot accept; hold PC and output stage.
REQ-006 Port: halt_req  in  1  stop fetching permanently (until reset).
REQ-007 Port: redirect_en  in  1  branch/jump taken; load redirect_pc.
REQ-008 Port: redirect_pc  in  32  redirect target byte address.
REQ-009 Port: im_addr  out  10  word address to instruction memory, = pc[11:2], combinational from PC register.
REQ-010 Port: im_rd  in  32  instruction word from memory, combinational read of im_addr.
REQ-011 Port: instr_out  out  32  registered fetched instruction.
REQ-012 Port: pc_out  out  32  registered byte address of instr_out.
REQ-013 Port: valid_out  out  1  instr_out/pc_out hold a live instruction.
REQ-014 Port: halted  out  1  sequencer in HALT state.
REQ-015 Port: err  out  1  sticky; halt caused by illegal address.

Function
REQ-016 States SHALL be BOOT, FETCH, STALL, HALT, held in a registered state variable; halted SHALL be 1 exactly when state is HALT.
REQ-017 BOOT SHALL last exactly one cycle, then move to FETCH unconditionally; stall, halt_req and redirect_en are ignored in BOOT.
REQ-018 An address is legal iff RESET_PC <= addr <= LAST_PC and addr[1:0] == 2'b00.
REQ-019 Input priority in FETCH and STALL SHALL be redirect_en > halt_req > stall.
REQ-020 FETCH, redirect_en with legal target: pc <= redirect_pc, valid_out <= 0 (bubble), instr_out/pc_out unchanged, stay FETCH.
REQ-021 FETCH or STALL, redirect_en with illegal target: state <= HALT, err <= 1, valid_out <= 0, pc unchanged.
REQ-022 FETCH, halt_req (no redirect): state <= HALT, valid_out <= 0, err unchanged.
REQ-023 FETCH, stall (no redirect/halt): state <= STALL; pc, instr_out, pc_out, valid_out held.
REQ-024 FETCH, no control input: instr_out <= im_rd, pc_out <= pc, valid_out <= 1, pc <= pc + 4; fetch latency is one cycle from PC to outputs.
REQ-025 FETCH, sequential fetch at pc == LAST_PC: the word SHALL be delivered per REQ-024, then state <= HALT, err <= 1, pc held at LAST_PC (no wrap to RESET_PC).
REQ-026 STALL, stall still 1 (no redirect/halt): all registers held.
REQ-027 STALL, stall 0 (no redirect/halt): state <= FETCH with no register update that cycle; fetch resumes at the held pc next cycle.
REQ-028 STALL, legal redirect_en: pc <= redirect_pc, valid_out <= 0, state <= FETCH (redirect overrides stall).
REQ-029 HALT SHALL be absorbing: only reset exits; valid_out stays 0; im_addr continues to reflect held pc.
REQ-030 pc arithmetic SHALL be 32-bit unsigned; im_addr SHALL never be driven from an illegal pc.

Reset
REQ-031 On reset (sampled high at clk edge), regardless of state: state <= BOOT, pc <= RESET_PC, instr_out <= 0, pc_out <= 0, valid_out <= 0, err <= 0.
REQ-032 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all other inputs in that cycle.

Verification
REQ-033 Reset, then 4 idle cycles with im = word index -> cycle1 BOOT valid 0; cycles 2-4 pc_out 0x3000,0x3004,0x3008, instr_out 0,1,2, valid 1.
REQ-034 stall high 3 cycles during FETCH -> instr_out/pc_out/valid frozen 3 cycles plus 1 resume cycle, then pc_out advances by exactly 4, no word skipped or duplicated.
REQ-035 redirect_en with redirect_pc 0x3100 -> next cycle valid_out 0; following cycle pc_out 0x3100, instr_out = im word 0x040.
REQ-036 redirect_en with 0x3102 (misaligned) or 0x2FFC -> next cycle halted 1, err 1, valid_out 0; further inputs ignored.
REQ-037 Redirect to 0x3FF8, run -> pc_out 0x3FF8, 0x3FFC delivered, then halted 1, err 1, no fetch at 0x4000/0x3000.
REQ-038 halt_req and stall same cycle -> HALT, err 0; then reset in HALT -> BOOT, all outputs 0, fetch restarts at 0x3000.
